// File: rtl/bram_pkg.sv
// Shared BRAM geometry and fetch-FSM state encoding for the connected-domain filter.
package bram_pkg;

  localparam int unsigned BRAM_ADDR_W   = 13;
  localparam int unsigned BRAM_DATA_W   = 32;
  localparam int unsigned WORDS_PER_ROW = 16;
  localparam int unsigned ROW_W         = 512;
  localparam int unsigned ROW_IDX_W     = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/bram_row_fetcher.sv
// Reads one 512-pixel row as 16 BRAM words over the trig/done handshake
// and publishes it as a complete 512-bit vector; aborts on a silent responder.
module bram_row_fetcher
  import bram_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                   i_clk,
  input  logic                   i_rstn,
  input  logic                   i_start,
  input  logic [ROW_IDX_W-1:0]   i_row,
  output logic [BRAM_ADDR_W-1:0] o_bram_addr,
  output logic                   o_bram_trig,
  input  logic [BRAM_DATA_W-1:0] i_bram_data,
  input  logic                   i_bram_done,
  output logic [ROW_W-1:0]       o_row_data,
  output logic                   o_row_valid,
  output logic                   o_busy,
  output logic                   o_err
);

  localparam int unsigned    TO_W   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYC);

  state_e                 state_q,     state_d;
  logic [ROW_IDX_W-1:0]   row_q,       row_d;
  logic [3:0]             word_idx_q,  word_idx_d;
  logic [TO_W-1:0]        to_cnt_q,    to_cnt_d;
  logic [TO_W-1:0]        to_next;
  logic [3:0]             word_sel;
  logic [ROW_W-1:0]       staging_q,   staging_d;
  logic [ROW_W-1:0]       row_data_q,  row_data_d;
  logic                   row_valid_q, row_valid_d;
  logic                   trig_q,      trig_d;
  logic                   busy_q,      busy_d;
  logic                   err_q,       err_d;

  // Next-state and registered-output computation for the fetch sequence.
  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    word_idx_d  = word_idx_q;
    to_cnt_d    = to_cnt_q;
    staging_d   = staging_q;
    row_data_d  = row_data_q;
    row_valid_d = 1'b0;
    err_d       = 1'b0;
    to_next     = (to_cnt_q == TO_MAX) ? TO_MAX : to_cnt_q + 1'b1;
    word_sel    = ~word_idx_q;

    case (state_q)
      IDLE: begin
        if (i_start) begin
          row_d      = i_row;
          word_idx_d = '0;
          to_cnt_d   = '0;
          state_d    = REQ;
        end
      end
      REQ: begin
        if (i_bram_done) begin
          staging_d[word_sel*BRAM_DATA_W +: BRAM_DATA_W] = i_bram_data;
          if (word_idx_q == 4'd15) begin
            // Publish on entry to DONE so o_row_data and o_row_valid
            // appear together in the DONE cycle.
            row_data_d  = staging_d;
            row_valid_d = 1'b1;
            state_d     = DONE;
          end else begin
            word_idx_d = word_idx_q + 4'd1;
            state_d    = GAP;
          end
        end else begin
          to_cnt_d = to_next;
          if (to_next == TO_MAX) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      GAP: begin
        to_cnt_d = '0;
        state_d  = REQ;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    trig_d = (state_d == REQ);
    busy_d = (state_d != IDLE);
  end

  // State and output registers, cleared asynchronously so a reset aborts a fetch at once.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q     <= IDLE;
      row_q       <= '0;
      word_idx_q  <= '0;
      to_cnt_q    <= '0;
      staging_q   <= '0;
      row_data_q  <= '0;
      row_valid_q <= 1'b0;
      trig_q      <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      word_idx_q  <= word_idx_d;
      to_cnt_q    <= to_cnt_d;
      staging_q   <= staging_d;
      row_data_q  <= row_data_d;
      row_valid_q <= row_valid_d;
      trig_q      <= trig_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign o_bram_addr = {row_q, word_idx_q};
  assign o_bram_trig = trig_q;
  assign o_row_data  = row_data_q;
  assign o_row_valid = row_valid_q;
  assign o_busy      = busy_q;
  assign o_err       = err_q;

endmodule
